// File: rtl/demorgan_sweep_ctrl.sv
// Exhaustive sweep sequencer for a NOR datapath; each result is checked against ~a & ~b.
// Optional build macro STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module demorgan_sweep_ctrl #(
    parameter int WIDTH       = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    input  logic [WIDTH-1:0]   dut_e,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b
);

    localparam int VW = 2 * WIDTH;
    localparam int CW = 2 * WIDTH + 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    state_t           state, state_nxt;
    logic [VW-1:0]    vec;
    logic [HW-1:0]    hold_cnt;
    logic [WIDTH-1:0] expect_e;
    logic             mismatch;
    logic             last_vec;
    logic             hold_last;
    logic             sweep_end;

    assign a_out     = vec[VW-1:WIDTH];
    assign b_out     = vec[WIDTH-1:0];
    assign expect_e  = ~a_out & ~b_out;
    assign mismatch  = (state == CHECK) && (dut_e != expect_e);
    assign last_vec  = (vec == '1);
    assign hold_last = (hold_cnt == HOLD_LAST);

`ifdef STOP_ON_FAIL_EN
    assign sweep_end = last_vec || mismatch;
`else
    assign sweep_end = last_vec;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = APPLY;
                end
            end
            APPLY: begin
                busy = 1'b1;
                if (hold_last) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                busy      = 1'b1;
                state_nxt = sweep_end ? DONE : APPLY;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // pass is resolved on the CHECK->DONE edge so it is already valid during the done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec       <= '0;
            hold_cnt  <= '0;
            err_count <= '0;
            pass      <= 1'b0;
            fail_a    <= '0;
            fail_b    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vec       <= '0;
                        hold_cnt  <= '0;
                        err_count <= '0;
                        pass      <= 1'b0;
                        fail_a    <= '0;
                        fail_b    <= '0;
                    end
                end
                APPLY: begin
                    hold_cnt <= hold_last ? '0 : hold_cnt + HW'(1);
                end
                CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count + CW'(1);
                        if (err_count == '0) begin
                            fail_a <= a_out;
                            fail_b <= b_out;
                        end
                    end
                    if (sweep_end) begin
                        pass <= (err_count == '0) && !mismatch;
                    end else begin
                        vec <= vec + VW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_demorgan_sweep_ctrl.sv
// Bench for demorgan_sweep_ctrl: two instances (HOLD_CYCLES 1 and 3) checked every cycle
// against a sweep-timeline model, plus literal expectations for the known datapath faults.
module tb_demorgan_sweep_ctrl;

    localparam int W    = 2;
    localparam int NV   = 1 << (2 * W);
    localparam int CW   = 2 * W + 1;
    localparam int MASK = (1 << W) - 1;
`ifdef STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start [2] = '{1'b0, 1'b0};
    logic [W-1:0]  a_o [2];
    logic [W-1:0]  b_o [2];
    logic [W-1:0]  e_i [2] = '{'0, '0};
    logic          busy_v [2];
    logic          done_v [2];
    logic          pass_v [2];
    logic [CW-1:0] ec [2];
    logic [W-1:0]  fa [2];
    logic [W-1:0]  fb [2];

    // model state: t = periods since the accepting start edge (-1 = no sweep since reset)
    int            t [2] = '{-1, -1};
    int            nend [2] = '{NV, NV};
    logic [W-1:0]  resp [2][NV];
    int            mode = 0;
    int            cyc = 0;
    int            kcyc = 0;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    demorgan_sweep_ctrl #(.WIDTH(W), .HOLD_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[0]),
        .a_out(a_o[0]), .b_out(b_o[0]), .dut_e(e_i[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .err_count(ec[0]), .fail_a(fa[0]), .fail_b(fb[0])
    );

    demorgan_sweep_ctrl #(.WIDTH(W), .HOLD_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start[1]),
        .a_out(a_o[1]), .b_out(b_o[1]), .dut_e(e_i[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .err_count(ec[1]), .fail_a(fa[1]), .fail_b(fb[1])
    );

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[inst %0d] cycle %0d: got %0h expected %0h", nm, i, cyc, act, exp);
        end
    endtask

    function automatic int hold_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int nor_ref(input int v);
        int a;
        int b;
        a = v >> W;
        b = v & MASK;
        return (~a & ~b) & MASK;
    endfunction

    function automatic bit bad(input int i, input int j);
        return int'(resp[i][j]) != nor_ref(j);
    endfunction

    task automatic accept(input int i);
        int a;
        int b;
        int ff;
        ff = -1;
        for (int j = 0; j < NV; j++) begin
            a = j >> W;
            b = j & MASK;
            case (mode)
                0:       resp[i][j] = W'(nor_ref(j));
                1:       resp[i][j] = '0;
                2:       resp[i][j] = W'(a | b);
                default: resp[i][j] = ($urandom_range(3) == 0) ? W'($urandom) : W'(nor_ref(j));
            endcase
            if (ff < 0 && bad(i, j)) ff = j;
        end
        nend[i] = (STOP && ff >= 0) ? ff + 1 : NV;
        t[i] = 0;
    endtask

    task automatic model_check(input int i);
        int p, h, d, idx, err, first;
        logic [31:0] ebusy, edone, epass, ea, eb, efa, efb;
        h = hold_of(i);
        p = h + 1;
        d = nend[i] * p;
        if (rst || t[i] < 0) begin
            ebusy = 0; edone = 0; epass = 0; ea = 0; eb = 0; efa = 0; efb = 0; err = 0;
        end else begin
            ebusy = (t[i] < d) ? 1 : 0;
            edone = (t[i] == d) ? 1 : 0;
            idx   = (t[i] < d) ? t[i] / p : nend[i] - 1;
            err   = 0;
            first = -1;
            for (int j = 0; j < nend[i]; j++) begin
                if (j * p + h < t[i] && bad(i, j)) begin
                    err++;
                    if (first < 0) first = j;
                end
            end
            epass = (t[i] >= d && err == 0) ? 1 : 0;
            ea    = idx >> W;
            eb    = idx & MASK;
            efa   = (first < 0) ? 0 : first >> W;
            efb   = (first < 0) ? 0 : first & MASK;
        end
        chk("busy", i, busy_v[i], ebusy);
        chk("done", i, done_v[i], edone);
        chk("pass", i, pass_v[i], epass);
        chk("a_out", i, a_o[i], ea);
        chk("b_out", i, b_o[i], eb);
        chk("err_count", i, ec[i], err);
        chk("fail_a", i, fa[i], efa);
        chk("fail_b", i, fb[i], efb);
    endtask

    // datapath response: table value only in the CHECK period, noise everywhere else
    task automatic drive_e(input int i);
        int p, d;
        p = hold_of(i) + 1;
        d = nend[i] * p;
        if (!rst && t[i] >= 0 && t[i] < d && (t[i] % p) == p - 1)
            e_i[i] = resp[i][t[i] / p];
        else
            e_i[i] = W'($urandom);
    endtask

    task automatic advance(input int i);
        int d;
        d = nend[i] * (hold_of(i) + 1);
        if (rst) t[i] = -1;
        else if (t[i] < 0 || t[i] > d) begin
            if (start[i]) accept(i);
        end else t[i] = t[i] + 1;
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            model_check(i);
            drive_e(i);
            advance(i);
        end
    end

    task automatic pulse(input int i);
        @(posedge clk); #1 start[i] = 1'b1;
        @(posedge clk); #1 start[i] = 1'b0;
        kcyc = cyc;
    endtask

    task automatic wait_done(input int i, output int off);
        int lim;
        lim = cyc + 200;
        while (done_v[i] !== 1'b1 && cyc < lim) @(negedge clk);
        if (done_v[i] !== 1'b1) chk("done_timeout", i, 0, 1);
        off = cyc - kcyc;
    endtask

    task automatic sweep_lit(input int i, input int m, input int off_exp, input int err_exp, input int pass_exp);
        int off;
        mode = m;
        pulse(i);
        wait_done(i, off);
        chk("done_offset", i, off, off_exp);
        chk("err_lit", i, ec[i], err_exp);
        chk("pass_lit", i, pass_v[i], pass_exp);
        chk("fail_a_lit", i, fa[i], 0);
        chk("fail_b_lit", i, fb[i], 0);
    endtask

    initial begin
        int off;
        repeat (2) @(negedge clk);
        chk("reset_busy", 0, busy_v[0], 0);
        chk("reset_err", 1, ec[1], 0);
        @(posedge clk); #1 rst = 1'b0;

        sweep_lit(0, 0, 32, 0, 1);
        if (STOP) sweep_lit(0, 1, 2, 1, 0);
        else      sweep_lit(0, 1, 32, 7, 0);
        if (STOP) sweep_lit(0, 2, 2, 1, 0);
        else      sweep_lit(0, 2, 32, 16, 0);
        sweep_lit(1, 0, 64, 0, 1);

        // re-pulse while busy is ignored
        mode = 0;
        pulse(0);
        repeat (4) @(posedge clk);
        #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        wait_done(0, off);
        chk("busy_restart_offset", 0, off, 32);

        // reset mid-sweep with errors already counted
        mode = 1;
        pulse(0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_a_out", 0, a_o[0], 0);
        chk("rst_err", 0, ec[0], 0);
        chk("rst_busy", 0, busy_v[0], 0);
        @(posedge clk); #1 rst = 1'b0;
        sweep_lit(0, 0, 32, 0, 1);

        // start held high across DONE
        mode = 0;
        @(posedge clk); #1 start[0] = 1'b1;
        @(posedge clk); #1 kcyc = cyc;
        wait_done(0, off);
        chk("held_offset", 0, off, 32);
        @(negedge clk);
        chk("held_idle_gap", 0, busy_v[0], 0);
        @(negedge clk);
        chk("held_restart", 0, busy_v[0], 1);
        @(posedge clk); #1 start[0] = 1'b0;
        wait_done(0, off);

        for (int n = 0; n < 30; n++) begin
            int i;
            i = $urandom_range(1);
            mode = $urandom_range(3);
            pulse(i);
            if ($urandom_range(4) == 0) begin
                repeat ($urandom_range(1, 40)) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
            end else begin
                wait_done(i, off);
            end
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
